alu_acc_pipe: RTL and testbench

//  Parametrised, registered successor to the 4-bit combinational ALU: the same 8-op set at WIDTH bits.

---
 rtl/alu_acc_pipe.sv | 163 ++++++++++++++++
 tb/tb_alu_acc_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_pipe.sv
// alu_acc_pipe
//   Registered WIDTH-bit ALU with a one-deep output stage, valid/ready
//   handshake on both sides, an internal accumulator and carry/zero flags.
//   Sits between the operand source and the result consumer.
//
//   Build option: define ALU_SAT_EN to make ops 1-3 saturate unsigned
//   (add overflow -> all ones, sub underflow -> 0). When ALU_SAT_EN is not
//   defined, ops 1-3 wrap mod 2^WIDTH and no saturation logic is built.
//
// Parameters
//   WIDTH     operand/result width (>= 2)
//   ACC_INIT  accumulator value after reset and after acc_clr
//
// Ports
//   Clock      in   rising-edge clock
//   Resetn     in   asynchronous active-low reset
//   in_valid   in   operation presented this cycle
//   in_ready   out  operation can be accepted this cycle
//   S          in   opcode: 0 zero, 1 B-A, 2 A-B, 3 A+B, 4 xor, 5 or, 6 and, 7 ones
//   A, B       in   operands (A replaced by acc when acc_sel=1)
//   acc_sel    in   use accumulator as operand A
//   acc_wr     in   load result into accumulator on accept
//   acc_clr    in   synchronous accumulator clear, independent of handshake
//   out_valid  out  F/carryout/zero hold a valid result
//   out_ready  in   consumer takes the result this cycle
//   F          out  registered result
//   carryout   out  add carry / sub borrow, 0 for other ops
//   zero       out  F == 0
//   acc        out  current accumulator value

module alu_acc_pipe #(
  parameter int unsigned            WIDTH    = 8,
  parameter logic [WIDTH-1:0]       ACC_INIT = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_sel,
  input  logic             acc_wr,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             carryout,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_BSA  = 3'd1,
    OP_ASB  = 3'd2,
    OP_ADD  = 3'd3,
    OP_XOR  = 3'd4,
    OP_OR   = 3'd5,
    OP_AND  = 3'd6,
    OP_ONES = 3'd7
  } op_t;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   bsa_ext;
  logic [WIDTH:0]   asb_ext;
  logic [WIDTH-1:0] f_next;
  logic             c_next;

  // The output stage frees up in the same cycle the consumer drains it,
  // so a full-rate stream never sees a bubble.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The accumulator register already holds the previous accepted result
  // when acc_wr was set, so back-to-back accumulation needs no bypass.
  assign op_a = acc_sel ? acc : A;

  // One extra bit captures carry on add and borrow on subtract.
  assign sum_ext = {1'b0, op_a} + {1'b0, B};
  assign bsa_ext = {1'b0, B} - {1'b0, op_a};
  assign asb_ext = {1'b0, op_a} - {1'b0, B};

  always_comb begin
    f_next = '0;
    c_next = 1'b0;
    unique case (op_t'(S))
      OP_ZERO: begin
        f_next = '0;
      end
      OP_BSA: begin
        c_next = bsa_ext[WIDTH];
`ifdef ALU_SAT_EN
        f_next = bsa_ext[WIDTH] ? '0 : bsa_ext[WIDTH-1:0];
`else
        f_next = bsa_ext[WIDTH-1:0];
`endif
      end
      OP_ASB: begin
        c_next = asb_ext[WIDTH];
`ifdef ALU_SAT_EN
        f_next = asb_ext[WIDTH] ? '0 : asb_ext[WIDTH-1:0];
`else
        f_next = asb_ext[WIDTH-1:0];
`endif
      end
      OP_ADD: begin
        c_next = sum_ext[WIDTH];
`ifdef ALU_SAT_EN
        f_next = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
        f_next = sum_ext[WIDTH-1:0];
`endif
      end
      OP_XOR: begin
        f_next = op_a ^ B;
      end
      OP_OR: begin
        f_next = op_a | B;
      end
      OP_AND: begin
        f_next = op_a & B;
      end
      OP_ONES: begin
        f_next = '1;
      end
      default: begin
        f_next = '0;
      end
    endcase
  end

  // Output stage: load on accept, drop valid once drained, otherwise hold.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out_valid <= 1'b0;
      F         <= '0;
      carryout  <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      F         <= f_next;
      carryout  <= c_next;
      zero      <= (f_next == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Clear takes priority over a coinciding accumulate write.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc <= ACC_INIT;
    end else if (acc_clr) begin
      acc <= ACC_INIT;
    end else if (accept && acc_wr) begin
      acc <= f_next;
    end
  end

endmodule

// File: tb/tb_alu_acc_pipe.sv
module tb_alu_acc_pipe;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   S;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         acc_sel;
  logic         acc_wr;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] F;
  logic         carryout;
  logic         zero;
  logic [W-1:0] acc;

  int n_cmp = 0;
  int n_err = 0;

  alu_acc_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .A        (A),
    .B        (B),
    .acc_sel  (acc_sel),
    .acc_wr   (acc_wr),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .F        (F),
    .carryout (carryout),
    .zero     (zero),
    .acc      (acc)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sel, input logic wr);
    in_valid = 1'b1;
    S        = s;
    A        = a;
    B        = b;
    acc_sel  = sel;
    acc_wr   = wr;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] f, input logic c, input logic z);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".F"},     {24'd0, F},         {24'd0, f});
    chk({tag, ".carry"}, {31'd0, carryout},  {31'd0, c});
    chk({tag, ".zero"},  {31'd0, zero},      {31'd0, z});
  endtask

  initial begin
    Resetn    = 1'b0;
    in_valid  = 1'b0;
    S         = 3'd0;
    A         = '0;
    B         = '0;
    acc_sel   = 1'b0;
    acc_wr    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.F",     {24'd0, F},         32'd0);
    chk("rst.carry", {31'd0, carryout},  32'd0);
    chk("rst.zero",  {31'd0, zero},      32'd0);
    chk("rst.acc",   {24'd0, acc},       32'd0);
    chk("rst.ready", {31'd0, in_ready},  32'd1);
    Resetn = 1'b1;
    tick();

    // Add with carry
    op(3'd3, 8'hF0, 8'h20, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
`ifdef ALU_SAT_EN
    chk_out("add", 8'hFF, 1'b1, 1'b0);
`else
    chk_out("add", 8'h10, 1'b1, 1'b0);
`endif
    tick();
    chk("drain.valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_SAT_EN
    chk("drain.Fhold", {24'd0, F}, 32'hFF);
`else
    chk("drain.Fhold", {24'd0, F}, 32'h10);
`endif

    // Add wrapping exactly to zero
    op(3'd3, 8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
`ifdef ALU_SAT_EN
    chk_out("addwrap", 8'hFF, 1'b1, 1'b0);
`else
    chk_out("addwrap", 8'h00, 1'b1, 1'b1);
`endif

    // Subtract both directions, back-to-back
    op(3'd2, 8'h05, 8'h07, 1'b0, 1'b0);
    tick();
`ifdef ALU_SAT_EN
    chk_out("asb", 8'h00, 1'b1, 1'b1);
`else
    chk_out("asb", 8'hFE, 1'b1, 1'b0);
`endif
    op(3'd1, 8'h05, 8'h07, 1'b0, 1'b0);
    tick();
    chk_out("bsa", 8'h02, 1'b0, 1'b0);

    // Constant and logic ops
    op(3'd0, 8'h5A, 8'hA5, 1'b0, 1'b0);
    tick();
    chk_out("zero_op", 8'h00, 1'b0, 1'b1);
    op(3'd7, 8'h5A, 8'hA5, 1'b1, 1'b0);
    tick();
    chk_out("ones_op", 8'hFF, 1'b0, 1'b0);
    op(3'd4, 8'h0F, 8'h3C, 1'b0, 1'b0);
    tick();
    chk_out("xor", 8'h33, 1'b0, 1'b0);
    op(3'd5, 8'h0F, 8'h3C, 1'b0, 1'b0);
    tick();
    chk_out("or", 8'h3F, 1'b0, 1'b0);
    op(3'd6, 8'h0F, 8'h3C, 1'b0, 1'b0);
    tick();
    chk_out("and", 8'h0C, 1'b0, 1'b0);
    in_valid = 1'b0;

    // Accumulate: clear, then four back-to-back +3
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("clr.acc", {24'd0, acc}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      op(3'd3, 8'h55, 8'h03, 1'b1, 1'b1);
      chk("accum.ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk_out("accum", 8'(3 * k), 1'b0, 1'b0);
      chk("accum.acc", {24'd0, acc}, 32'(3 * k));
    end

    // Clear wins over accumulate write; F still produced
    op(3'd3, 8'h00, 8'h01, 1'b1, 1'b1);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk_out("clrpri", 8'h0D, 1'b0, 1'b0);
    chk("clrpri.acc", {24'd0, acc}, 32'd0);

    // Backpressure: first result pending, second op held for 3 cycles
    op(3'd3, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    chk_out("bp.first", 8'h33, 1'b0, 1'b0);
    out_ready = 1'b0;
    op(3'd3, 8'h01, 8'h02, 1'b0, 1'b0);
    #1;
    chk("bp.ready0", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp.stall_ready", {31'd0, in_ready}, 32'd0);
      chk_out("bp.hold", 8'h33, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready1", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk_out("bp.second", 8'h03, 1'b0, 1'b0);
    tick();
    chk("bp.nodup", {31'd0, out_valid}, 32'd0);

    // Async reset mid-cycle with a pending result and acc=0C
    op(3'd3, 8'h06, 8'h06, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk_out("pre_rst", 8'h0C, 1'b0, 1'b0);
    chk("pre_rst.acc", {24'd0, acc}, 32'h0C);
    #2;
    Resetn = 1'b0;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.F",     {24'd0, F},         32'd0);
    chk("arst.acc",   {24'd0, acc},       32'd0);
    tick();
    Resetn    = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst.valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
